// File: rtl/ram_io_frame_strobe_sequencer_pkg.sv
// Shared types and widths for the column frame-strobe sequencer.
// No logic. The timer helper converts a cycle count into a down-counter load value.
package cfg_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } seq_state_t;

    localparam int TIMER_W          = 4;
    localparam int FRAMES_WRITTEN_W = 16;

    // The timer counts down to zero inclusive, so N cycles load N-1.
    function automatic logic [TIMER_W-1:0] timer_load(input int cycles);
        return TIMER_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ram_io_frame_strobe_sequencer_addr_onehot.sv
// Binary frame index to one-hot strobe select, plus an in-range flag.
// Purely combinational, zero latency, no flow control.
module frame_addr_onehot #(
    parameter int N      = 20,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [N-1:0]      onehot_o,
    output logic              in_range_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            if (32'(addr_i) == 32'(i)) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

    assign in_range_o = (32'(addr_i) < 32'(N));

endmodule

// File: rtl/ram_io_frame_strobe_sequencer.sv
// Column config sequencer: one frame write at a time, driven as data plus a timed one-hot strobe.
// Latency Setup+Strobe+Hold cycles per frame; Ready is low while busy, so requesters must hold Valid.
module ram_io_frame_strobe_sequencer
    import cfg_frame_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int SetupCycles     = 1,
    parameter int StrobeCycles    = 2,
    parameter int HoldCycles      = 1,
    localparam int AddrW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
    input  logic                        UserCLK,
    input  logic                        Reset,
    input  logic                        FrameReqValid,
    output logic                        FrameReqReady,
    input  logic [AddrW-1:0]            FrameReqAddr,
    input  logic [FrameBitsPerRow-1:0]  FrameReqData,
    output logic [FrameBitsPerRow-1:0]  FrameData,
    output logic [MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                        Busy,
    output logic                        AddrError,
    output logic [FRAMES_WRITTEN_W-1:0] FramesWritten
);

    if (StrobeCycles < 1 || StrobeCycles > 15) begin : g_bad_strobe
        $error("StrobeCycles must be in 1..15");
    end
    if (SetupCycles < 0 || SetupCycles > 15 || HoldCycles < 0 || HoldCycles > 15) begin : g_bad_timing
        $error("SetupCycles and HoldCycles must be in 0..15");
    end
    if (MaxFramesPerCol < 1) begin : g_bad_frames
        $error("MaxFramesPerCol must be at least 1");
    end

    seq_state_t                  state_q;
    logic [TIMER_W-1:0]          timer_q;
    logic [MaxFramesPerCol-1:0]  sel_q;
    logic [MaxFramesPerCol-1:0]  strobe_q;
    logic [FrameBitsPerRow-1:0]  data_q;
    logic                        addr_err_q;
    logic [FRAMES_WRITTEN_W-1:0] frames_written_q;
    logic [FRAMES_WRITTEN_W-1:0] frames_written_d;

    logic [MaxFramesPerCol-1:0]  req_onehot;
    logic                        req_in_range;
    logic                        accept;
    logic                        strobe_exit;

    frame_addr_onehot #(
        .N      (MaxFramesPerCol),
        .ADDR_W (AddrW)
    ) u_addr_onehot (
        .addr_i     (FrameReqAddr),
        .onehot_o   (req_onehot),
        .in_range_o (req_in_range)
    );

    assign FrameReqReady = (state_q == IDLE) && !Reset;
    assign accept        = FrameReqValid && FrameReqReady;
    assign strobe_exit   = (state_q == STROBE) && (timer_q == '0);

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            sel_q      <= '0;
            strobe_q   <= '0;
            data_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_in_range) begin
                            data_q <= FrameReqData;
                            sel_q  <= req_onehot;
                            if (SetupCycles == 0) begin
                                state_q  <= STROBE;
                                timer_q  <= timer_load(StrobeCycles);
                                strobe_q <= req_onehot;
                            end else begin
                                state_q <= SETUP;
                                timer_q <= timer_load(SetupCycles);
                            end
                        end else begin
                            // Rejected index: stay idle so the next request can land immediately.
                            addr_err_q <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    if (timer_q == '0) begin
                        state_q  <= STROBE;
                        timer_q  <= timer_load(StrobeCycles);
                        strobe_q <= sel_q;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                STROBE: begin
                    if (timer_q == '0) begin
                        strobe_q <= '0;
                        if (HoldCycles == 0) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= HOLD;
                            timer_q <= timer_load(HoldCycles);
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                HOLD: begin
                    if (timer_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A frame only counts once its strobe has completed; reset mid-strobe drops it.
    always_comb begin
        frames_written_d = frames_written_q;
        if (strobe_exit && (frames_written_q != '1)) begin
            frames_written_d = frames_written_q + 1'b1;
        end
    end

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            frames_written_q <= '0;
        end else begin
            frames_written_q <= frames_written_d;
        end
    end

    assign FrameData     = data_q;
    assign FrameStrobe   = strobe_q;
    assign Busy          = (state_q != IDLE);
    assign AddrError     = addr_err_q;
    assign FramesWritten = frames_written_q;

    a_strobe_onehot: assert property (@(posedge UserCLK) disable iff (Reset)
        (state_q == STROBE) |-> $onehot(strobe_q));
    a_strobe_quiet: assert property (@(posedge UserCLK) disable iff (Reset)
        (state_q != STROBE) |-> (strobe_q == '0));

endmodule

// File: tb/tb_ram_io_frame_strobe_sequencer.sv
// Directed bench: default-timing instance plus an S=0/W=1/H=0 corner instance.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_ram_io_frame_strobe_sequencer;

    logic        clk = 1'b0;
    logic        rst;

    logic        vld, rdy, busy, aerr;
    logic [4:0]  addr;
    logic [31:0] dat, fdata;
    logic [19:0] fstrobe;
    logic [15:0] fw;

    logic        vld_c, rdy_c, busy_c, aerr_c;
    logic [4:0]  addr_c;
    logic [31:0] dat_c, fdata_c;
    logic [19:0] fstrobe_c;
    logic [15:0] fw_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ram_io_frame_strobe_sequencer dut (
        .UserCLK       (clk),
        .Reset         (rst),
        .FrameReqValid (vld),
        .FrameReqReady (rdy),
        .FrameReqAddr  (addr),
        .FrameReqData  (dat),
        .FrameData     (fdata),
        .FrameStrobe   (fstrobe),
        .Busy          (busy),
        .AddrError     (aerr),
        .FramesWritten (fw)
    );

    ram_io_frame_strobe_sequencer #(
        .SetupCycles  (0),
        .StrobeCycles (1),
        .HoldCycles   (0)
    ) dut_c (
        .UserCLK       (clk),
        .Reset         (rst),
        .FrameReqValid (vld_c),
        .FrameReqReady (rdy_c),
        .FrameReqAddr  (addr_c),
        .FrameReqData  (dat_c),
        .FrameData     (fdata_c),
        .FrameStrobe   (fstrobe_c),
        .Busy          (busy_c),
        .AddrError     (aerr_c),
        .FramesWritten (fw_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Called on a falling edge with the default instance idle; accept lands on the next rising edge.
    task automatic write_dflt(input logic [4:0] a, input logic [31:0] d,
                              input logic [19:0] exp_strobe, input logic [15:0] exp_cnt);
        vld = 1'b1; addr = a; dat = d;
        @(negedge clk);
        vld = 1'b0;
        check("w_c1_data",   fdata,   d);
        check("w_c1_strobe", fstrobe, 32'h0);
        check("w_c1_busy",   busy,    32'h1);
        check("w_c1_ready",  rdy,     32'h0);
        @(negedge clk);
        check("w_c2_strobe", fstrobe, exp_strobe);
        @(negedge clk);
        check("w_c3_strobe", fstrobe, exp_strobe);
        check("w_c3_data",   fdata,   d);
        @(negedge clk);
        check("w_c4_strobe", fstrobe, 32'h0);
        check("w_c4_busy",   busy,    32'h1);
        check("w_c4_count",  fw,      exp_cnt);
        @(negedge clk);
        check("w_c5_ready",  rdy,     32'h1);
        check("w_c5_busy",   busy,    32'h0);
        check("w_c5_data",   fdata,   d);
    endtask

    // Corner instance: strobe only in cycle 1, ready again in cycle 2.
    task automatic write_corner(input logic [4:0] a, input logic [31:0] d,
                                input logic [19:0] exp_strobe, input logic [15:0] exp_cnt);
        vld_c = 1'b1; addr_c = a; dat_c = d;
        @(negedge clk);
        vld_c = 1'b0;
        check("c_c1_strobe", fstrobe_c, exp_strobe);
        check("c_c1_busy",   busy_c,    32'h1);
        check("c_c1_ready",  rdy_c,     32'h0);
        check("c_c1_data",   fdata_c,   d);
        @(negedge clk);
        check("c_c2_strobe", fstrobe_c, 32'h0);
        check("c_c2_ready",  rdy_c,     32'h1);
        check("c_c2_count",  fw_c,      exp_cnt);
    endtask

    initial begin
        rst = 1'b1;
        vld = 1'b0;   addr = '0;   dat = '0;
        vld_c = 1'b0; addr_c = '0; dat_c = '0;

        // T1 reset
        repeat (3) @(negedge clk);
        check("rst_ready",  rdy,     32'h0);
        check("rst_data",   fdata,   32'h0);
        check("rst_strobe", fstrobe, 32'h0);
        check("rst_busy",   busy,    32'h0);
        check("rst_aerr",   aerr,    32'h0);
        check("rst_count",  fw,      32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready",   rdy,   32'h1);
        check("rel_ready_c", rdy_c, 32'h1);

        // T2 single write
        write_dflt(5'd5, 32'hDEADBEEF, 20'h00020, 16'd1);

        // T3 out-of-range requests, back to back
        vld = 1'b1; addr = 5'd20; dat = 32'h12345678;
        @(negedge clk);
        check("err20_pulse",  aerr,    32'h1);
        check("err20_strobe", fstrobe, 32'h0);
        check("err20_ready",  rdy,     32'h1);
        addr = 5'd31;
        @(negedge clk);
        vld = 1'b0;
        check("err31_pulse",  aerr,    32'h1);
        check("err31_data",   fdata,   32'hDEADBEEF);
        @(negedge clk);
        check("err_clear",    aerr,    32'h0);
        check("err_strobe",   fstrobe, 32'h0);
        check("err_count",    fw,      32'h1);
        check("err_data",     fdata,   32'hDEADBEEF);
        check("err_busy",     busy,    32'h0);

        // T4 back-to-back with Valid held high
        vld = 1'b1; addr = 5'd0; dat = 32'h1;
        @(negedge clk);
        addr = 5'd19; dat = 32'h2;
        check("b2b_c1_data",   fdata,   32'h1);
        check("b2b_c1_strobe", fstrobe, 32'h0);
        @(negedge clk);
        check("b2b_c2_strobe", fstrobe, 32'h00001);
        @(negedge clk);
        check("b2b_c3_strobe", fstrobe, 32'h00001);
        @(negedge clk);
        check("b2b_c4_strobe", fstrobe, 32'h0);
        check("b2b_c4_ready",  rdy,     32'h0);
        check("b2b_c4_data",   fdata,   32'h1);
        @(negedge clk);
        check("b2b_c5_ready",  rdy,     32'h1);
        check("b2b_c5_strobe", fstrobe, 32'h0);
        check("b2b_c5_count",  fw,      32'h2);
        @(negedge clk);
        vld = 1'b0;
        check("b2b_c6_data",   fdata,   32'h2);
        check("b2b_c6_busy",   busy,    32'h1);
        check("b2b_c6_strobe", fstrobe, 32'h0);
        @(negedge clk);
        check("b2b_c7_strobe", fstrobe, 32'h80000);
        @(negedge clk);
        check("b2b_c8_strobe", fstrobe, 32'h80000);
        @(negedge clk);
        check("b2b_c9_strobe", fstrobe, 32'h0);
        check("b2b_c9_count",  fw,      32'h3);
        @(negedge clk);
        check("b2b_c10_ready", rdy,     32'h1);

        // T5 reset in the first strobe cycle
        vld = 1'b1; addr = 5'd7; dat = 32'h55;
        @(negedge clk);
        vld = 1'b0;
        @(negedge clk);
        check("mid_strobe_on", fstrobe, 32'h00080);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_strobe", fstrobe, 32'h0);
        check("mid_rst_data",   fdata,   32'h0);
        check("mid_rst_count",  fw,      32'h0);
        check("mid_rst_busy",   busy,    32'h0);
        check("mid_rst_ready",  rdy,     32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_ready",  rdy,     32'h1);
        check("mid_rel_count",  fw,      32'h0);

        // T6 timing corner and counter saturation
        write_corner(5'd3, 32'hA5A5A5A5, 20'h00008, 16'd1);
        force dut_c.frames_written_q = 16'hFFFE;
        @(negedge clk);
        release dut_c.frames_written_q;
        @(negedge clk);
        check("sat_preload", fw_c, 32'hFFFE);
        write_corner(5'd1, 32'h0000_0011, 20'h00002, 16'hFFFF);
        write_corner(5'd2, 32'h0000_0022, 20'h00004, 16'hFFFF);
        check("sat_aerr_c", aerr_c, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
